i2c_transaction_sequencer: RTL
==============================

# i2c_transaction_sequencer

Multi-byte I2C transaction engine between the Avalon register bridge and the `i2c_master` byte engine. Accepts one command (7-bit address, direction, 1–4 bytes, packed write word), drives the master's `ena`/`data_wr` handshake byte by byte, and packs read bytes into a 32-bit result. Reports completion, ACK error, bad length and bus timeout on a held response interface.

## Interface
- `TIMEOUT_CYCLES`, default 1000000: clock cycles without a `m_busy` edge before the transaction is aborted (≥16).
- `clock` in 1: system clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_addr` in 7: I2C slave address.
- `cmd_rw` in 1: 0 = write, 1 = read.
- `cmd_len` in 3: byte count; 1–4 legal.
- `cmd_wdata` in 32: write bytes; byte k = bits [8k+7:8k], byte 0 sent first.
- `rsp_valid` out 1: response held until `rsp_ready`.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out 32: read bytes, same packing as `cmd_wdata`; unread bytes 0.
- `rsp_ack_error` out 1: slave NACK seen.
- `rsp_timeout` out 1: watchdog expired.
- `rsp_bad_len` out 1: `cmd_len` was 0 or >4; no bus activity.
- `m_ena`, `m_addr`[7], `m_rw`, `m_data_wr`[8] out: to `i2c_master`.
- `m_busy`, `m_ack_error` in 1; `m_data_rd` in 8: from `i2c_master`.

## Operation
- States: IDLE, ARM, XFER, DRAIN, RESP.
- `busy_prev` registers `m_busy` every cycle; rise = `m_busy & ~busy_prev`, fall = `~m_busy & busy_prev`.
- IDLE: `cmd_ready`=1. On `cmd_valid`: latch addr/rw/len/wdata into `m_addr`/`m_rw`/internal regs, `m_data_wr` ← byte 0, clear `rsp_rdata`, `idx`←0. Legal len → ARM with `m_ena`=1; illegal len → RESP with `rsp_bad_len`=1.
- ARM: wait for rise → XFER. Rise handling identical to XFER.
- Byte k occupies one busy-high period. On rise k: `m_data_wr` ← byte k+1 (unchanged if none); if k+1 = len, `m_ena`←0.
- On fall k: if read, `rsp_rdata[8k+7:8k]` ← `m_data_rd`; `idx`←k+1; if k+1 = len → RESP.
- `m_ack_error`=1 in ARM/XFER: `m_ena`←0, sticky error flag set, → DRAIN.
- DRAIN: wait until `m_busy`=0 for a sampled cycle → RESP; no further read capture.
- Watchdog: counter cleared on IDLE exit and every busy edge, increments in ARM/XFER/DRAIN; on reaching `TIMEOUT_CYCLES-1`: `m_ena`←0, `rsp_timeout`←1, → RESP directly. Timeout and NACK in same cycle: both flags set, → RESP.
- RESP: `rsp_valid`=1, flags/rdata stable; on `rsp_ready` → IDLE, clear flags. A new command is not accepted in the same cycle as `rsp_ready`.
- `m_addr`/`m_rw` held constant for the whole transaction.

## Timing
- Reset (async assert, sync release): state IDLE, `cmd_ready`=1, `m_ena`=0, `m_addr`=0, `m_rw`=0, `m_data_wr`=0, `rsp_valid`=0, `rsp_rdata`=0, all flags 0, counter 0, `busy_prev`=0.
- Reset mid-transaction: `m_ena` drops immediately; no response generated.
- Command accept to `m_ena`=1: 1 cycle.
- Rise/fall detected in cycle m_busy changes; resulting register updates visible next cycle.
- Last fall to `rsp_valid`=1: 1 cycle; bad-len accept to `rsp_valid`: 1 cycle.
- `m_ena` deasserted 1 cycle after rise of last byte, well inside master's byte period.
- `m_busy` stuck low in ARM: timeout exactly `TIMEOUT_CYCLES` cycles after `m_ena` rises.

## Test plan
- Write len=2, wdata=0x0000_BEEF, addr=0x50, master model → bytes 0xEF then 0xBE on bus, `m_ena` low after 2nd rise, `rsp_valid` with all flags 0.
- Read len=4, model returns 0x11,0x22,0x33,0x44 → `rsp_rdata`=0x4433_2211, exactly 4 busy periods.
- Read len=3 with NACK during byte 1 → `m_ena` drops next cycle, DRAIN until busy low, `rsp_ack_error`=1, `rsp_rdata`=0x0000_00xx (byte 0 only).
- `cmd_len`=0 and `cmd_len`=5 → `rsp_bad_len`=1 after 1 cycle, `m_ena` never asserted.
- `TIMEOUT_CYCLES`=16, `m_busy` tied 0 → `rsp_timeout`=1 exactly 16 cycles after `m_ena` high, `m_ena`=0.
- Assert `reset_n`=0 during byte 2 of a 4-byte write → all outputs at reset values same cycle; next command completes normally.

Source files
------------

// File: rtl/i2c_transaction_sequencer.sv
// i2c_transaction_sequencer
//
// Multi-byte I2C transaction engine sitting between the register bridge and
// the i2c_master byte engine. One command (7-bit address, direction, 1..4
// bytes, packed write word) is turned into a sequence of byte periods on the
// master's ena/data_wr handshake. Read bytes are packed into a 32-bit result.
// Completion, slave NACK, bad length and bus timeout are reported on a response
// interface that holds until consumed.
//
// Ports
//   clock, reset_n                 system clock, async active-low reset
//   cmd_valid / cmd_ready          command handshake (ready only when idle)
//   cmd_addr[7], cmd_rw            slave address, 0 = write / 1 = read
//   cmd_len[3], cmd_wdata[32]      byte count (1..4), byte k at [8k+7:8k]
//   rsp_valid / rsp_ready          response handshake (held until ready)
//   rsp_rdata[32]                  read bytes, same packing, unread bytes 0
//   rsp_ack_error, rsp_timeout,
//   rsp_bad_len                    status flags
//   m_ena, m_addr[7], m_rw,
//   m_data_wr[8]                   to i2c_master
//   m_busy, m_ack_error,
//   m_data_rd[8]                   from i2c_master

module i2c_transaction_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_addr,
  input  logic        cmd_rw,
  input  logic [2:0]  cmd_len,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_ack_error,
  output logic        rsp_timeout,
  output logic        rsp_bad_len,
  output logic        m_ena,
  output logic [6:0]  m_addr,
  output logic        m_rw,
  output logic [7:0]  m_data_wr,
  input  logic        m_busy,
  input  logic        m_ack_error,
  input  logic [7:0]  m_data_rd
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_XFER  = 3'd2,
    S_DRAIN = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic            busy_prev;
  logic            rise;
  logic            fall;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;
  logic [2:0]      len_r;
  logic [2:0]      idx;
  logic [2:0]      next_idx;
  logic            last_byte;
  logic            len_ok;
  logic [31:0]     wdata_r;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  assign rise      = m_busy & ~busy_prev;
  assign fall      = ~m_busy & busy_prev;
  assign next_idx  = idx + 3'd1;
  // idx counts completed bytes, so the byte in flight is the last one when
  // one more completion reaches the programmed length.
  assign last_byte = (next_idx == len_r);
  assign len_ok    = (cmd_len != 3'd0) && (cmd_len <= 3'd4);
  assign wd_hit    = ((state_q == S_ARM) || (state_q == S_XFER) || (state_q == S_DRAIN))
                     && (wd_cnt == WD_LAST);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The watchdog outranks a NACK: both flags get set but
  // the bus is abandoned rather than drained.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = len_ok ? S_ARM : S_RESP;
        end
      end
      S_ARM, S_XFER: begin
        if (wd_hit) begin
          state_d = S_RESP;
        end else if (m_ack_error) begin
          state_d = S_DRAIN;
        end else if ((state_q == S_ARM) && rise) begin
          state_d = S_XFER;
        end else if ((state_q == S_XFER) && fall && last_byte) begin
          state_d = S_RESP;
        end
      end
      S_DRAIN: begin
        if (wd_hit || !m_busy) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
  end

  // Handshake, capture and watchdog registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_prev     <= 1'b0;
      wd_cnt        <= '0;
      len_r         <= 3'd0;
      idx           <= 3'd0;
      m_ena         <= 1'b0;
      m_addr        <= 7'd0;
      m_rw          <= 1'b0;
      m_data_wr     <= 8'd0;
      rsp_rdata     <= 32'd0;
      rsp_ack_error <= 1'b0;
      rsp_timeout   <= 1'b0;
      rsp_bad_len   <= 1'b0;
    end else begin
      busy_prev <= m_busy;
      unique case (state_q)
        S_IDLE: begin
          wd_cnt <= '0;
          if (cmd_valid) begin
            m_addr    <= cmd_addr;
            m_rw      <= cmd_rw;
            len_r     <= cmd_len;
            m_data_wr <= cmd_wdata[7:0];
            rsp_rdata <= 32'd0;
            idx       <= 3'd0;
            if (len_ok) begin
              m_ena <= 1'b1;
            end else begin
              rsp_bad_len <= 1'b1;
            end
          end
        end
        S_ARM, S_XFER: begin
          wd_cnt <= (rise || fall) ? '0 : wd_cnt + 1'b1;
          if (wd_hit) begin
            m_ena       <= 1'b0;
            rsp_timeout <= 1'b1;
            if (m_ack_error) begin
              rsp_ack_error <= 1'b1;
            end
          end else if (m_ack_error) begin
            m_ena         <= 1'b0;
            rsp_ack_error <= 1'b1;
          end else begin
            // The master has latched the current byte once busy rises, so
            // data_wr can already move on to the next one.
            if (rise) begin
              if (last_byte) begin
                m_ena <= 1'b0;
              end else begin
                m_data_wr <= byte_sel(wdata_r, next_idx[1:0]);
              end
            end
            if (fall && (state_q == S_XFER)) begin
              if (m_rw) begin
                rsp_rdata[{idx[1:0], 3'b000} +: 8] <= m_data_rd;
              end
              idx <= next_idx;
            end
          end
        end
        S_DRAIN: begin
          wd_cnt <= (rise || fall) ? '0 : wd_cnt + 1'b1;
          if (wd_hit) begin
            rsp_timeout <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_ack_error <= 1'b0;
            rsp_timeout   <= 1'b0;
            rsp_bad_len   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Write payload is pure data and needs no reset.
  always_ff @(posedge clock) begin
    if ((state_q == S_IDLE) && cmd_valid) begin
      wdata_r <= cmd_wdata;
    end
  end

endmodule
